// File: rtl/arms_launcher.sv
// Multi-slot arcing projectile generator for one player; also tracks the opponent's HP.
// Each slot climbs to the apex, falls, and is retired on a hit, a side bound or the ground.
module arms_launcher #(
  parameter int SLOTS     = 2,
  parameter int DIR_RIGHT = 1,
  parameter int COORD_W   = 7,
  parameter int HP_W      = 8,
  parameter int HP_INIT   = 100,
  parameter int DAMAGE    = 10,
  parameter int APEX_Y    = 21,
  parameter int GROUND_Y  = 39,
  parameter int X_MAX     = 62,
  parameter int X_MIN     = 2,
  parameter int HIT_XL    = 2,
  parameter int HIT_XR    = 2,
  parameter int HIT_YT    = 2,
  parameter int HIT_YB    = 3,
  parameter int COOLDOWN  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick_slow,
  input  logic                     tick_fast,
  input  logic                     fire,
  input  logic [2:0]               state,
  input  logic [COORD_W-1:0]       own_x,
  input  logic [COORD_W-1:0]       own_y,
  input  logic [COORD_W-1:0]       opp_x,
  input  logic [COORD_W-1:0]       opp_y,
  output logic [SLOTS*COORD_W-1:0] arms_x,
  output logic [SLOTS*COORD_W-1:0] arms_y,
  output logic [SLOTS-1:0]         arms_active,
  output logic [HP_W-1:0]          opp_hp,
  output logic                     hit_pulse
);

  localparam logic [2:0] ST_GAME = 3'd1;
  localparam int CD_W  = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  localparam int SW    = COORD_W + 1;
  localparam int DMG_W = HP_W + 3;
  localparam logic signed [SW-1:0] HXL = SW'(HIT_XL);
  localparam logic signed [SW-1:0] HXR = SW'(HIT_XR);
  localparam logic signed [SW-1:0] HYT = SW'(HIT_YT);
  localparam logic signed [SW-1:0] HYB = SW'(HIT_YB);

  typedef enum logic [1:0] {IDLE, UP, DOWN} slot_state_t;

  slot_state_t          slot_state_reg [SLOTS];
  logic [COORD_W-1:0]   x_reg [SLOTS];
  logic [COORD_W-1:0]   y_reg [SLOTS];
  logic [SLOTS-1:0]     active_reg;
  logic [SLOTS-1:0]     launch_sel;
  logic [SLOTS-1:0]     hit_vec;
  logic                 fire_q_reg;
  logic [CD_W-1:0]      cooldown_reg;
  logic [HP_W-1:0]      hp_reg;
  logic                 hit_pulse_reg;
  logic                 in_game;
  logic                 launch_ok;
  logic                 sel_found;
  logic [COORD_W-1:0]   anchor_x;
  logic [DMG_W-1:0]     damage;
  logic [HP_W-1:0]      hp_next;
  logic signed [SW-1:0] opp_xs;
  logic signed [SW-1:0] opp_ys;

  assign in_game   = (state == ST_GAME);
  assign anchor_x  = (DIR_RIGHT != 0) ? own_x + COORD_W'(1) : own_x - COORD_W'(1);
  assign launch_ok = in_game && fire && !fire_q_reg && (cooldown_reg == '0) && !(&active_reg);
  assign opp_xs    = signed'({1'b0, opp_x});
  assign opp_ys    = signed'({1'b0, opp_y});

  // Lowest-index idle slot wins the launch.
  always_comb begin
    launch_sel = '0;
    sel_found  = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (launch_ok && !sel_found && !active_reg[i]) begin
        launch_sel[i] = 1'b1;
        sel_found     = 1'b1;
      end
    end
  end

  always_comb begin
    damage = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (hit_vec[i]) damage = damage + DMG_W'(DAMAGE);
    end
    hp_next = ({3'b000, hp_reg} > damage) ? hp_reg - HP_W'(damage) : '0;
  end

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      logic signed [SW-1:0] xs;
      logic signed [SW-1:0] ys;
      logic                 in_box;
      logic                 out_of_bounds;
      logic [COORD_W-1:0]   x_step;

      assign xs     = signed'({1'b0, x_reg[gi]});
      assign ys     = signed'({1'b0, y_reg[gi]});
      assign in_box = (xs >= opp_xs - HXL) && (xs <= opp_xs + HXR) &&
                      (ys >= opp_ys - HYT) && (ys <= opp_ys + HYB);
      assign out_of_bounds = ((DIR_RIGHT != 0) ? (x_reg[gi] >= COORD_W'(X_MAX))
                                               : (x_reg[gi] <= COORD_W'(X_MIN))) ||
                             (y_reg[gi] >= COORD_W'(GROUND_Y));
      assign x_step  = (DIR_RIGHT != 0) ? x_reg[gi] + COORD_W'(1) : x_reg[gi] - COORD_W'(1);
      assign hit_vec[gi] = in_game && tick_fast && (slot_state_reg[gi] == DOWN) && in_box;

      always_ff @(posedge clk) begin
        if (rst || !in_game) begin
          slot_state_reg[gi] <= IDLE;
          active_reg[gi]     <= 1'b0;
          x_reg[gi]          <= anchor_x;
          y_reg[gi]          <= own_y;
        end else begin
          case (slot_state_reg[gi])
            IDLE: begin
              if (launch_sel[gi]) begin
                slot_state_reg[gi] <= UP;
                active_reg[gi]     <= 1'b1;
              end else begin
                x_reg[gi] <= anchor_x;
                y_reg[gi] <= own_y;
              end
            end
            UP: begin
              if (tick_fast) begin
                x_reg[gi] <= x_step;
                if (y_reg[gi] <= COORD_W'(APEX_Y)) slot_state_reg[gi] <= DOWN;
                else y_reg[gi] <= y_reg[gi] - COORD_W'(1);
              end
            end
            DOWN: begin
              if (tick_fast) begin
                // A hit freezes the slot in place; the anchor reappears one cycle later.
                if (in_box || out_of_bounds) begin
                  slot_state_reg[gi] <= IDLE;
                  active_reg[gi]     <= 1'b0;
                end else begin
                  x_reg[gi] <= x_step;
                  y_reg[gi] <= y_reg[gi] + COORD_W'(1);
                end
              end
            end
            default: begin
              slot_state_reg[gi] <= IDLE;
              active_reg[gi]     <= 1'b0;
            end
          endcase
        end
      end

      assign arms_x[gi*COORD_W +: COORD_W] = x_reg[gi];
      assign arms_y[gi*COORD_W +: COORD_W] = y_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    fire_q_reg <= rst ? 1'b0 : fire;
    if (rst || !in_game) begin
      hp_reg        <= HP_W'(HP_INIT);
      cooldown_reg  <= '0;
      hit_pulse_reg <= 1'b0;
    end else begin
      hp_reg        <= hp_next;
      hit_pulse_reg <= |hit_vec;
      if (launch_ok) cooldown_reg <= CD_W'(COOLDOWN);
      else if (tick_slow && (cooldown_reg != '0)) cooldown_reg <= cooldown_reg - CD_W'(1);
    end
  end

  assign arms_active = active_reg;
  assign opp_hp      = hp_reg;
  assign hit_pulse   = hit_pulse_reg;

endmodule

// File: tb/tb_arms_launcher.sv
// Bench for arms_launcher: one right-facing and one left-facing instance share stimulus;
// a projectile-level model predicts every output each cycle, plus directed literal checks.
module tb_arms_launcher;
  localparam int NS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tick_slow, tick_fast, fire;
  logic [2:0] state;
  logic [6:0] own_x, own_y, own_lx, own_ly, opp_x, opp_y;
  logic [13:0] r_ax, r_ay, l_ax, l_ay;
  logic [1:0]  r_act, l_act;
  logic [7:0]  r_hp, l_hp;
  logic        r_pulse, l_pulse;

  arms_launcher #(.SLOTS(NS), .DIR_RIGHT(1)) dut_r (
    .clk(clk), .rst(rst), .tick_slow(tick_slow), .tick_fast(tick_fast), .fire(fire),
    .state(state), .own_x(own_x), .own_y(own_y), .opp_x(opp_x), .opp_y(opp_y),
    .arms_x(r_ax), .arms_y(r_ay), .arms_active(r_act), .opp_hp(r_hp), .hit_pulse(r_pulse));

  arms_launcher #(.SLOTS(NS), .DIR_RIGHT(0)) dut_l (
    .clk(clk), .rst(rst), .tick_slow(tick_slow), .tick_fast(tick_fast), .fire(fire),
    .state(state), .own_x(own_lx), .own_y(own_ly), .opp_x(opp_x), .opp_y(opp_y),
    .arms_x(l_ax), .arms_y(l_ay), .arms_active(l_act), .opp_hp(l_hp), .hit_pulse(l_pulse));

  int cmp_count = 0;
  int err_count = 0;
  bit started = 0;

  task automatic chk(input string name, input int act, input int exp);
    cmp_count++;
    if (act != exp) begin
      err_count++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Projectile-level model: 0 = idle, 1 = climbing, 2 = falling.
  int mst[2][NS], mx[2][NS], my[2][NS];
  int mhp[2], mcd[2], mpulse[2], mfq[2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int dir, ax, ay, lsel, hits, ox, oy;
      dir = (d == 0) ? 1 : -1;
      ax  = ((d == 0 ? int'(own_x) : int'(own_lx)) + dir) & 127;
      ay  = (d == 0) ? int'(own_y) : int'(own_ly);
      ox  = int'(opp_x);
      oy  = int'(opp_y);
      if (rst || state != 3'd1) begin
        for (int s = 0; s < NS; s++) begin
          mst[d][s] = 0; mx[d][s] = ax; my[d][s] = ay;
        end
        mhp[d] = 100; mcd[d] = 0; mpulse[d] = 0;
      end else begin
        lsel = -1;
        if (fire && !mfq[d] && mcd[d] == 0)
          for (int s = 0; s < NS; s++) if (mst[d][s] == 0 && lsel < 0) lsel = s;
        hits = 0;
        for (int s = 0; s < NS; s++) begin
          if (mst[d][s] == 0) begin
            if (s == lsel) mst[d][s] = 1;
            else begin mx[d][s] = ax; my[d][s] = ay; end
          end else if (tick_fast) begin
            if (mst[d][s] == 1) begin
              mx[d][s] = (mx[d][s] + dir) & 127;
              if (my[d][s] <= 21) mst[d][s] = 2;
              else my[d][s] = my[d][s] - 1;
            end else if (mx[d][s] >= ox - 2 && mx[d][s] <= ox + 2 &&
                         my[d][s] >= oy - 2 && my[d][s] <= oy + 3) begin
              hits++;
              mst[d][s] = 0;
            end else if ((dir > 0 ? mx[d][s] >= 62 : mx[d][s] <= 2) || my[d][s] >= 39) begin
              mst[d][s] = 0;
            end else begin
              mx[d][s] = (mx[d][s] + dir) & 127;
              my[d][s] = my[d][s] + 1;
            end
          end
        end
        mpulse[d] = (hits > 0);
        mhp[d] = mhp[d] - 10 * hits;
        if (mhp[d] < 0) mhp[d] = 0;
        if (lsel >= 0) mcd[d] = 4;
        else if (tick_slow && mcd[d] > 0) mcd[d] = mcd[d] - 1;
      end
      mfq[d] = rst ? 0 : int'(fire);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        string p;
        p = (d == 0) ? "r" : "l";
        for (int s = 0; s < NS; s++) begin
          chk($sformatf("%s_x%0d", p, s), (d == 0) ? int'(r_ax[s*7 +: 7]) : int'(l_ax[s*7 +: 7]), mx[d][s]);
          chk($sformatf("%s_y%0d", p, s), (d == 0) ? int'(r_ay[s*7 +: 7]) : int'(l_ay[s*7 +: 7]), my[d][s]);
          chk($sformatf("%s_active%0d", p, s), (d == 0) ? int'(r_act[s]) : int'(l_act[s]), int'(mst[d][s] != 0));
        end
        chk($sformatf("%s_hp", p), (d == 0) ? int'(r_hp) : int'(l_hp), mhp[d]);
        chk($sformatf("%s_pulse", p), (d == 0) ? int'(r_pulse) : int'(l_pulse), mpulse[d]);
      end
    end
  end

  task automatic cyc(input bit tf, input bit ts, input bit f);
    @(negedge clk);
    tick_fast = tf; tick_slow = ts; fire = f;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 100; i++) begin
      if (r_act == 2'b00 && l_act == 2'b00) break;
      cyc(1, 1, 0);
    end
    chk("drain_timeout", int'(r_act == 2'b00 && l_act == 2'b00), 1);
  endtask

  initial begin
    int seen, exp_hp;
    rst = 1; state = 3'd1; tick_fast = 0; tick_slow = 0; fire = 0;
    own_x = 10; own_y = 30; own_lx = 5; own_ly = 30; opp_x = 50; opp_y = 5;
    @(posedge clk);
    #1 started = 1;
    cyc(0, 0, 0);
    rst = 0;
    cyc(0, 0, 0);
    chk("reset_r_x0", int'(r_ax[6:0]), 11);
    chk("reset_r_y0", int'(r_ay[6:0]), 30);
    chk("reset_r_x1", int'(r_ax[13:7]), 11);
    chk("reset_hp", int'(r_hp), 100);
    chk("reset_active", int'(r_act), 0);
    chk("reset_l_x0", int'(l_ax[6:0]), 4);

    // Single flight, opponent far away
    own_lx = 30;
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("launch_r_active", int'(r_act), 1);
    chk("launch_l_active", int'(l_act), 1);
    repeat (9) cyc(1, 1, 0);
    cyc(0, 0, 0);
    chk("apex_r_x", int'(r_ax[6:0]), 20);
    chk("apex_r_y", int'(r_ay[6:0]), 21);
    chk("apex_l_x", int'(l_ax[6:0]), 20);
    cyc(1, 1, 0);
    cyc(0, 0, 0);
    chk("turn_r_x", int'(r_ax[6:0]), 21);
    chk("turn_r_y", int'(r_ay[6:0]), 21);
    chk("turn_l_x", int'(l_ax[6:0]), 19);
    drain();
    chk("miss_hp", int'(r_hp), 100);

    // Repeated hits down to and past zero HP
    opp_x = 25; opp_y = 28;
    for (int k = 1; k <= 11; k++) begin
      cyc(0, 0, 1);
      cyc(0, 0, 0);
      seen = 0;
      for (int i = 0; i < 60; i++) begin
        cyc(1, 1, 0);
        if (r_pulse) begin seen = 1; break; end
      end
      exp_hp = 100 - 10 * k;
      if (exp_hp < 0) exp_hp = 0;
      chk($sformatf("hit%0d_seen", k), seen, 1);
      chk($sformatf("hit%0d_hp", k), int'(r_hp), exp_hp);
      chk($sformatf("hit%0d_slot_idle", k), int'(r_act[0]), 0);
      cyc(0, 0, 0);
      chk($sformatf("hit%0d_pulse_len", k), int'(r_pulse), 0);
    end

    // Leaving GAME mid-flight
    cyc(0, 0, 1);
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    chk("menu_pre_active", int'(r_act[0]), 1);
    state = 3'd0;
    cyc(0, 0, 0);
    chk("menu_active", int'(r_act), 0);
    chk("menu_hp", int'(r_hp), 100);
    state = 3'd1;
    cyc(0, 0, 0);

    // Held fire, cooldown and slot exhaustion
    opp_x = 50; opp_y = 5;
    drain();
    cyc(0, 0, 1); cyc(0, 0, 1); cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("held_one_launch", int'(r_act), 1);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("cooldown_drop", int'(r_act), 1);
    repeat (4) cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("second_slot", int'(r_act), 3);
    repeat (4) cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("full_drop", int'(r_act), 3);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      cyc(($urandom % 3) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0);
      rst = (($urandom % 500) == 0);
      if (($urandom % 100) == 0) state = (($urandom % 10) < 7) ? 3'd1 : 3'($urandom % 6);
      if (($urandom % 40) == 0) begin
        opp_x = 7'($urandom_range(10, 60));
        opp_y = 7'($urandom_range(18, 40));
      end
      if (($urandom % 150) == 0) begin
        own_x = 7'($urandom_range(5, 55)); own_y = 7'($urandom_range(20, 35));
        own_lx = 7'($urandom_range(10, 60)); own_ly = 7'($urandom_range(20, 35));
      end
    end
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end
endmodule

// File: doc/arms_launcher.md
# arms_launcher

Parametrised multi-slot projectile ("arms") generator for one player in the two-player arena game. It replaces the per-player, single-shot, clock-switched arms generators with one block. The block is instanced once per player and selects facing direction by parameter. It runs up to SLOTS independent arcing projectiles on a 10-pixel grid, uses clock-enable ticks instead of gated clocks, and owns the opponent's HP counter.

## Interface
Parameters:
- SLOTS, 2: number of simultaneous projectiles (1..4).
- DIR_RIGHT, 1: 1 = projectiles travel +x (player 1), 0 = travel −x (player 2).
- COORD_W, 7: grid coordinate width.
- HP_W, 8: HP width.
- HP_INIT, 100: opponent HP after reset and outside GAME.
- DAMAGE, 10: HP removed per hit.
- APEX_Y, 21: y at or above which the climb ends.
- GROUND_Y, 39: y at or below which the projectile is discarded.
- X_MAX, 62 / X_MIN, 2: x bounds; a projectile that reaches a bound in its travel direction is discarded.
- HIT_XL, 2 / HIT_XR, 2 / HIT_YT, 2 / HIT_YB, 3: hitbox extents relative to opponent location.
- COOLDOWN, 4: tick_slow periods between launches.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick_slow  in  1  one-cycle enable; cooldown timebase
- tick_fast  in  1  one-cycle enable; flight step
- fire  in  1  attack key (level)
- state  in  3  game state (MENU 0, GAME 1, P1WIN 2, P2WIN 3, TIE 4, PIONT 5)
- own_x, own_y  in  COORD_W  each  thrower location
- opp_x, opp_y  in  COORD_W  each  target location
- arms_x, arms_y  out  SLOTS*COORD_W  each  packed slot positions; slot i occupies bits [i*COORD_W +: COORD_W]
- arms_active  out  SLOTS  slot i in flight
- opp_hp  out  HP_W  opponent HP
- hit_pulse  out  1  one-cycle pulse on any hit

## Operation
- Each slot has three states: IDLE, UP, DOWN. The anchor is (own_x+1, own_y) when DIR_RIGHT=1, else (own_x−1, own_y).
- IDLE slot: arms_x/arms_y track the anchor every cycle, and arms_active=0.
- Launch occurs when state==GAME, fire & ~fire_q (rising edge), cooldown==0, and at least one slot is IDLE. The lowest-index IDLE slot goes to UP at its current position, and cooldown loads COORD­OWN=COOLDOWN. Fires that do not meet these conditions are dropped, not queued.
- On tick_fast, each non-IDLE slot steps once:
  - x moves ±1 in the travel direction.
  - UP: if y ≤ APEX_Y, go to DOWN with y unchanged; else y−1.
  - DOWN, checked in priority order:
    1. Hit, when opp_x−HIT_XL ≤ x ≤ opp_x+HIT_XR and opp_y−HIT_YT ≤ y ≤ opp_y+HIT_YB. The slot goes to IDLE and is not moved.
    2. Out of bounds, when x ≥ X_MAX (right) or x ≤ X_MIN (left), or y ≥ GROUND_Y. The slot goes to IDLE.
    3. Otherwise y+1.
- All hitbox comparisons use COORD_W+1-bit signed arithmetic, so opp_x−HIT_XL never wraps.
- HP: k simultaneous hits in one step subtract k*DAMAGE, saturating at 0. hit_pulse asserts for any hit, including when HP is already 0.
- Cooldown decrements on tick_slow while nonzero.
- When state≠GAME, every cycle: all slots IDLE, opp_hp=HP_INIT, cooldown=0, hit_pulse=0.

## Timing
- All outputs are registered. On reset: all slots IDLE at the anchor, arms_active=0, opp_hp=HP_INIT, hit_pulse=0, cooldown=0, fire_q=0.
- Launch to arms_active=1 takes 1 clk. The first movement happens on the first tick_fast strictly after the launch cycle.
- Launch and tick_fast in the same cycle: the launching slot does not move, and other slots step normally.
- Hit to opp_hp update and hit_pulse is 1 clk after the tick_fast cycle. The hit slot shows the anchor on the following cycle.
- Reset or a state change out of GAME mid-flight takes effect on the next edge, and no damage is applied that cycle.

## Test plan
- Reset, state=GAME, own=(10,30), DIR_RIGHT=1 → arms_x=11, arms_y=30, opp_hp=100, arms_active=0.
- Single fire, opp far at (50,5), ticks only on tick_fast:
  - slot0 climbs from y=30 to 21 in 9 steps, reaching x=20.
  - Next step: DOWN, x=21.
  - Descends until y=39, then IDLE; opp_hp stays 100.
- Opp at (25,28), fire → hit on the DOWN step where x=23..27 and y in 26..31 → opp_hp=90, hit_pulse high for exactly 1 clk, slot IDLE.
- Repeated hits from HP_INIT=100 → opp_hp 90…0. The 11th hit leaves opp_hp=0 with hit_pulse=1.
- Fire held high → 1 launch. Second edge within COOLDOWN → dropped. Edge after cooldown with SLOTS=2 → slot1 launches while slot0 is in flight. Third edge with both busy → dropped.
- DIR_RIGHT=0, own=(5,30) → anchor x=4; x decrements and the slot is discarded at x=2. Switching state to MENU mid-flight → all IDLE and opp_hp=100 next cycle.
